// File: rtl/vga_scan.sv
// rtl/vga_scan.sv - 640x480 raster timing generator with latency-aligned sync and RGB output stage
module vga_scan #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          PIX_LAT  = 1,
    parameter logic [11:0] FG_COLOR = 12'hFFF,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixel_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        newframe,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb
);

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_PRE    = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_newframe;
    logic        r_hsync;
    logic        r_vsync;
    logic [11:0] r_rgb;
    logic [2:0]  r_dly [PIX_LAT];

    logic        w_active;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic        w_line_end;
    logic [2:0]  w_dly_out;

    assign w_line_end = (r_x == H_LAST);
    assign w_active   = (r_x < H_ACT) && (r_y < V_ACT);
    assign w_hs_raw   = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
    assign w_vs_raw   = (r_y >= VS_FIRST) && (r_y <= VS_LAST);
    assign w_dly_out  = r_dly[PIX_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_newframe <= 1'b0;
        end else begin
            r_x <= w_line_end ? 10'd0 : r_x + 10'd1;
            if (w_line_end) begin
                r_y <= (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
            end
            // Pulse lands on the cycle where the counters read x=0, y=V_ACTIVE
            r_newframe <= w_line_end && (r_y == V_PRE);
        end
    end

    // {active, hs_raw, vs_raw} delayed to line up with the renderer's answer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PIX_LAT; i++) begin
                r_dly[i] <= 3'b000;
            end
        end else begin
            r_dly[0] <= {w_active, w_hs_raw, w_vs_raw};
            for (int i = 1; i < PIX_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 12'h000;
        end else begin
            r_hsync <= ~w_dly_out[1];
            r_vsync <= ~w_dly_out[0];
            // pixel_in is only looked at inside the visible area
            r_rgb   <= w_dly_out[2] ? (pixel_in ? FG_COLOR : BG_COLOR) : 12'h000;
        end
    end

    assign x        = r_x;
    assign y        = r_y;
    assign newframe = r_newframe;
    assign active   = w_active;
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign rgb      = r_rgb;

endmodule

// File: tb/tb_vga_scan.sv
// tb/tb_vga_scan.sv - self-checking bench for vga_scan on a reduced raster geometry
module tb_vga_scan;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6;
    localparam int VA = 12, VF = 2, VS = 2, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LAT = 2;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h00F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pixel_in = 1'b0;
    logic [9:0]  x, y;
    logic        newframe, active, hsync, vsync;
    logic [11:0] rgb;

    vga_scan #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_LAT(LAT), .FG_COLOR(FG), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst_n), .pixel_in(pixel_in),
        .x(x), .y(y), .newframe(newframe), .active(active),
        .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic        pix;
        int          ex;
        int          ey;
        logic        eact;
        logic        enf;
        logic        ehs;
        logic        evs;
        logic [11:0] ergb;
    } vec_t;

    vec_t tbl [19];
    int   n_vec = 0;
    int   n_err = 0;
    int   k = 0;
    logic pix_hist [4096];

    function automatic logic [35:0] pack_out();
        return {x, y, newframe, active, hsync, vsync, rgb};
    endfunction

    task automatic cmp(input string name, input logic [35:0] got, input logic [35:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s k=%0d got %h expected %h", name, k, got, want);
        end
    endtask

    task automatic drive_step(input logic p);
        pixel_in   = p;
        pix_hist[k] = p;
        @(negedge clk);
        k++;
    endtask

    // Reference: counters are k mod line/frame; delayed outputs reflect counters LAT+1 cycles back
    function automatic logic [35:0] model(input int kk);
        int ex, ey, j, jx, jy;
        logic eact, enf, ehs, evs;
        logic [11:0] ergb;
        ex   = kk % HT;
        ey   = (kk / HT) % VT;
        eact = (ex < HA) && (ey < VA);
        enf  = (ex == 0) && (ey == VA);
        if (kk < LAT + 1) begin
            ehs = 1'b1; evs = 1'b1; ergb = 12'h000;
        end else begin
            j    = kk - LAT - 1;
            jx   = j % HT;
            jy   = (j / HT) % VT;
            ehs  = !((jx >= HA + HF) && (jx < HA + HF + HS));
            evs  = !((jy >= VA + VF) && (jy < VA + VF + VS));
            ergb = ((jx < HA) && (jy < VA)) ? (pix_hist[kk-1] ? FG : BG) : 12'h000;
        end
        return {10'(ex), 10'(ey), enf, eact, ehs, evs, ergb};
    endfunction

    initial begin
        int nf_cnt, nf_last, nf_gap, vs_first;
        tbl[0]  = '{0,   1'b0, 0,  0,  1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[1]  = '{1,   1'b0, 1,  0,  1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[2]  = '{2,   1'b1, 2,  0,  1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[3]  = '{3,   1'b1, 3,  0,  1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF};
        tbl[4]  = '{4,   1'b0, 4,  0,  1'b1, 1'b0, 1'b1, 1'b1, 12'h00F};
        tbl[5]  = '{19,  1'b1, 19, 0,  1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[6]  = '{23,  1'b1, 23, 0,  1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[7]  = '{28,  1'b1, 28, 0,  1'b0, 1'b0, 1'b0, 1'b1, 12'h000};
        tbl[8]  = '{29,  1'b1, 29, 0,  1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[9]  = '{32,  1'b1, 0,  1,  1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[10] = '{35,  1'b1, 3,  1,  1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF};
        tbl[11] = '{384, 1'b1, 0,  12, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000};
        tbl[12] = '{385, 1'b1, 1,  12, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[13] = '{450, 1'b1, 2,  14, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[14] = '{451, 1'b1, 3,  14, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[15] = '{514, 1'b1, 2,  16, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[16] = '{515, 1'b1, 3,  16, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[17] = '{640, 1'b1, 0,  0,  1'b1, 1'b0, 1'b1, 1'b1, 12'h000};
        tbl[18] = '{643, 1'b1, 3,  0,  1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF};

        repeat (3) @(negedge clk);
        cmp("reset_hold", pack_out(), model(0));
        rst_n = 1'b1;
        k = 0;

        foreach (tbl[i]) begin
            while (k < tbl[i].k) drive_step(tbl[i].pix);
            cmp($sformatf("table_%0d", i), pack_out(),
                {10'(tbl[i].ex), 10'(tbl[i].ey), tbl[i].enf, tbl[i].eact,
                 tbl[i].ehs, tbl[i].evs, tbl[i].ergb});
        end

        // Random pixels over two more frames, stopping inside hsync+vsync
        nf_cnt = 0; nf_last = 0; nf_gap = 0;
        while (k < 1785) begin
            drive_step(1'($urandom_range(0, 1)));
            cmp("random_run", pack_out(), model(k));
            if (newframe === 1'b1) begin
                if (nf_cnt > 0) nf_gap = k - nf_last;
                nf_cnt++;
                nf_last = k;
            end
        end
        cmp("newframe_count", 36'(nf_cnt), 36'd2);
        cmp("newframe_period", 36'(nf_gap), 36'(HT * VT));

        // Asynchronous reset while both syncs are low
        cmp("pre_reset_syncs", {34'd0, hsync, vsync}, 36'd0);
        #2 rst_n = 1'b0;
        #1 cmp("async_reset", {x, y, newframe, hsync, vsync, rgb}, {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 12'h000});
        repeat (3) @(negedge clk);
        k = 0;
        cmp("reset_mid_hold", pack_out(), model(0));
        rst_n = 1'b1;

        vs_first = -1;
        while (k < 700) begin
            drive_step(1'($urandom_range(0, 1)));
            cmp("after_reset", pack_out(), model(k));
            if (vsync === 1'b0 && vs_first < 0) vs_first = k;
        end
        cmp("first_vsync_after_reset", 36'(vs_first), 36'((VA + VF) * HT + LAT + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
